ex_stage_md: RTL and testbench

- Parametrised successor to the combinational execute stage of the pipelined MIPS core.
- Keeps the same operand-A/B selection, ALU and destination-register selection. Adds a registered EX/MEM output with valid/ready handshake, HI/LO registers and an iterative multiply/divide unit that back-pressures the ID stage while busy.
- Sits between the ID/EX register and the MEM stage.

---
 rtl/ex_pkg.sv | 41 ++++
 rtl/ex_stage_md_md_iter_unit.sv | 117 +++++++++++
 rtl/ex_stage_md.sv | 151 +++++++++++++++
 tb/tb_ex_stage_md.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU and mul/div opcodes, mul/div FSM
// states and operand-B select codes.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } md_state_e;

    localparam logic [1:0] SRC_B_RT   = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;
    localparam logic [1:0] SRC_B_IMMC = 2'd3;

endpackage

// File: rtl/ex_stage_md_md_iter_unit.sv
// Iterative radix-2 multiply (shift-add) / restoring divide on magnitudes.
// The last of the DATA_W steps is evaluated combinationally while in DONE.
module md_iter_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic              is_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              ack,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc_hi, acc_lo, b_mag_r, a_raw;
    logic              op_div, neg_res, neg_rem, div_zero;
    logic [DATA_W-1:0] a_mag, b_mag, step_hi, step_lo, quo, rem;
    logic [DATA_W:0]   sum, trial;
    logic [2*DATA_W-1:0] prod;

    assign a_mag = (is_signed && a[DATA_W-1]) ? -a : a;
    assign b_mag = (is_signed && b[DATA_W-1]) ? -b : b;
    assign busy  = (state == ST_BUSY);
    assign done  = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == CNT_W'(DATA_W - 2)) state_nxt = ST_DONE;
            ST_DONE: if (ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        sum     = '0;
        trial   = '0;
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (op_div) begin
            trial   = {acc_hi, acc_lo[DATA_W-1]};
            step_lo = {acc_lo[DATA_W-2:0], 1'b0};
            if (trial >= {1'b0, b_mag_r}) begin
                trial      = trial - {1'b0, b_mag_r};
                step_lo[0] = 1'b1;
            end
            step_hi = trial[DATA_W-1:0];
        end else begin
            sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag_r} : '0);
            step_hi = sum[DATA_W:1];
            step_lo = {sum[0], acc_lo[DATA_W-1:1]};
        end
    end

    // Sign fix-up; the remainder follows the dividend's sign.
    always_comb begin
        prod = {step_hi, step_lo};
        quo  = neg_res ? -step_lo : step_lo;
        rem  = neg_rem ? -step_hi : step_hi;
        if (neg_res) prod = -prod;
        if (!op_div) begin
            hi = prod[2*DATA_W-1:DATA_W];
            lo = prod[DATA_W-1:0];
        end else if (div_zero) begin
            hi = a_raw;
            lo = '1;
        end else begin
            hi = rem;
            lo = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            b_mag_r  <= '0;
            a_raw    <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                cnt      <= '0;
                acc_hi   <= '0;
                acc_lo   <= a_mag;
                b_mag_r  <= b_mag;
                a_raw    <= a;
                op_div   <= is_div;
                neg_res  <= is_signed && (a[DATA_W-1] ^ b[DATA_W-1]);
                neg_rem  <= is_signed && a[DATA_W-1];
                div_zero <= (b == '0);
            end else if (state == ST_BUSY) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage with registered EX/MEM output, HI/LO and iterative mul/div.
// Define FAST_MUL_EN for a single-cycle combinational MULT/MULTU.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    output logic               ex_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [2:0]         md_op,
    input  logic               alu_src_a,
    input  logic [1:0]         alu_src_b,
    input  logic               is_shift,
    input  logic               reg_dst,
    input  logic [REG_AW-1:0]  rt,
    input  logic [REG_AW-1:0]  rd,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  immc,
    input  logic [DATA_W-1:0]  pc_plus,
    input  logic               mem_ready,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  alu_out,
    output logic [DATA_W-1:0]  store_data,
    output logic [REG_AW-1:0]  r3_addr,
    output logic               md_busy
);

    logic [DATA_W-1:0]  op_a, op_b, alu_res, result_sel, hi_r, lo_r, md_hi, md_lo;
    logic [SHAMT_W-1:0] sh;
    logic u_busy, u_done, accept, is_mult_op, is_div_op, md_signed, iter_start, md_ack;

    assign is_mult_op = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div_op  = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign md_signed  = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign md_busy    = u_busy || u_done;
    assign ex_ready   = !md_busy && (!ex_valid || mem_ready);
    assign accept     = id_valid && ex_ready;
    assign md_ack     = !ex_valid || mem_ready;

`ifdef FAST_MUL_EN
    logic [2*DATA_W-1:0] product;
    assign product    = {{DATA_W{md_signed && rs_data[DATA_W-1]}}, rs_data}
                      * {{DATA_W{md_signed && rt_data[DATA_W-1]}}, rt_data};
    assign iter_start = accept && is_div_op;
`else
    assign iter_start = accept && (is_div_op || is_mult_op);
`endif

    md_iter_unit #(.DATA_W(DATA_W)) u_md (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (iter_start),
        .is_signed (md_signed),
        .is_div    (is_div_op),
        .a         (rs_data),
        .b         (rt_data),
        .ack       (md_ack),
        .busy      (u_busy),
        .done      (u_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        op_a = alu_src_a ? (is_shift ? {{(DATA_W-SHAMT_W){1'b0}}, shamt} : rs_data)
                         : pc_plus - DATA_W'(4);
        case (alu_src_b)
            SRC_B_RT:   op_b = rt_data;
            SRC_B_FOUR: op_b = DATA_W'(4);
            SRC_B_IMM:  op_b = imm;
            default:    op_b = immc;
        endcase
    end

    assign sh = op_a[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:  alu_res = op_b << sh;
            ALU_SRL:  alu_res = op_b >> sh;
            ALU_SRA:  alu_res = $signed(op_b) >>> sh;
            ALU_LUI:  alu_res = op_b << (DATA_W / 2);
            default:  alu_res = '0;
        endcase
    end

    // The reserved md_op encoding falls through to the plain ALU result.
    always_comb begin
        case (md_op)
            MD_MFHI: result_sel = hi_r;
            MD_MFLO: result_sel = lo_r;
            default: result_sel = alu_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            alu_out    <= '0;
            store_data <= '0;
            r3_addr    <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
        end else if (accept) begin
            store_data <= rt_data;
            if (iter_start) begin
                ex_valid <= 1'b0;
            end
`ifdef FAST_MUL_EN
            else if (is_mult_op) begin
                ex_valid <= 1'b1;
                alu_out  <= '0;
                r3_addr  <= '0;
                hi_r     <= product[2*DATA_W-1:DATA_W];
                lo_r     <= product[DATA_W-1:0];
            end
`endif
            else begin
                ex_valid <= 1'b1;
                alu_out  <= result_sel;
                r3_addr  <= reg_dst ? rd : rt;
            end
        end else if (u_done && md_ack) begin
            ex_valid <= 1'b1;
            alu_out  <= '0;
            r3_addr  <= '0;
            hi_r     <= md_hi;
            lo_r     <= md_lo;
        end else if (mem_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: directed cases from the test plan followed
// by randomized traffic with random MEM back-pressure.
module tb_ex_stage_md;

   localparam int W  = 32;
   localparam int AW = 5;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst_n, id_valid, ex_ready, alu_src_a, is_shift, reg_dst, mem_ready;
   logic          ex_valid, md_busy;
   logic [3:0]    alu_ctrl;
   logic [2:0]    md_op;
   logic [1:0]    alu_src_b;
   logic [AW-1:0] rt, rd, r3_addr;
   logic [SW-1:0] shamt;
   logic [W-1:0]  rs_data, rt_data, imm, immc, pc_plus, alu_out, store_data;

   ex_stage_md #(.DATA_W(W), .REG_AW(AW), .SHAMT_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .ex_ready(ex_ready),
      .alu_ctrl(alu_ctrl), .md_op(md_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .is_shift(is_shift), .reg_dst(reg_dst), .rt(rt), .rd(rd), .shamt(shamt),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .immc(immc), .pc_plus(pc_plus),
      .mem_ready(mem_ready), .ex_valid(ex_valid), .alu_out(alu_out),
      .store_data(store_data), .r3_addr(r3_addr), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    alu_ctrl;
      logic [2:0]    md_op;
      logic          alu_src_a;
      logic [1:0]    alu_src_b;
      logic          is_shift;
      logic          reg_dst;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic [SW-1:0] shamt;
      logic [W-1:0]  rs_data;
      logic [W-1:0]  rt_data;
      logic [W-1:0]  imm;
      logic [W-1:0]  immc;
      logic [W-1:0]  pc_plus;
   } stim_t;

   typedef struct {
      logic [W-1:0]  alu;
      logic [AW-1:0] r3;
      logic [W-1:0]  st;
      int            acc;
      int            lat;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] m_hi, m_lo;
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   bit           rand_on = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference ALU written from the operation definitions, not from the RTL.
   function automatic logic [W-1:0] model_alu(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      int        n;
      longint    sb64;
      logic [63:0] wide;
      n = int'(a % 32);
      sb64 = longint'($signed(b));
      wide = {32'b0, b};
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  begin wide = wide * (64'd1 << n); return wide[31:0]; end
         4'd9:  begin wide = wide / (64'd1 << n); return wide[31:0]; end
         4'd10: begin
                   sb64 = (sb64 >= 0) ? sb64 / (64'sd1 <<< n)
                                      : -((-sb64 + (64'sd1 <<< n) - 1) / (64'sd1 <<< n));
                   return sb64[31:0];
                end
         4'd11: begin wide = wide * 64'd65536; return wide[31:0]; end
         default: return '0;
      endcase
   endfunction

   task automatic model_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint      p;
      logic [63:0] pu;
      int          sa, sbv;
      sa = a;
      sbv = b;
      case (op)
         3'd1: begin p = longint'(sa) * longint'(sbv); {m_hi, m_lo} = p; end
         3'd2: begin pu = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = pu; end
         3'd3: begin
                  if (b == 0) begin m_lo = '1; m_hi = a; end
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
                  else begin m_lo = sa / sbv; m_hi = sa % sbv; end
               end
         3'd4: begin
                  if (b == 0) begin m_lo = '1; m_hi = a; end
                  else begin m_lo = a / b; m_hi = a % b; end
               end
         default: ;
      endcase
   endtask

   function automatic stim_t blank();
      stim_t s;
      s = '{alu_ctrl: 4'd0, md_op: 3'd0, alu_src_a: 1'b1, alu_src_b: 2'd0, is_shift: 1'b0,
            reg_dst: 1'b0, rt: '0, rd: '0, shamt: '0, rs_data: '0, rt_data: '0,
            imm: '0, immc: '0, pc_plus: '0};
      return s;
   endfunction

   // Drives one entry, waits for its accept, pushes the expected response.
   task automatic applyStimulus(input stim_t s, input bit lat_chk, output int waited);
      exp_t        e;
      logic [W-1:0] a, b;
      bit          md_iter, accepted;
      alu_ctrl = s.alu_ctrl; md_op = s.md_op; alu_src_a = s.alu_src_a; alu_src_b = s.alu_src_b;
      is_shift = s.is_shift; reg_dst = s.reg_dst; rt = s.rt; rd = s.rd; shamt = s.shamt;
      rs_data = s.rs_data; rt_data = s.rt_data; imm = s.imm; immc = s.immc; pc_plus = s.pc_plus;
      id_valid = 1'b1;
      waited = 0;
      accepted = 0;
      while (!accepted && waited <= 200) begin
         @(negedge clk);
         if (ex_ready) accepted = 1;
         else waited++;
      end
      if (!accepted) begin
         checkOutput("accept_timeout", 64'(waited), 64'd0);
      end else begin
         md_iter = (s.md_op >= 3'd1 && s.md_op <= 3'd4);
         a = s.alu_src_a ? (s.is_shift ? W'(s.shamt) : s.rs_data) : s.pc_plus - 4;
         case (s.alu_src_b)
            2'd0: b = s.rt_data;
            2'd1: b = 4;
            2'd2: b = s.imm;
            default: b = s.immc;
         endcase
         e.st  = s.rt_data;
         e.acc = cyc;
         if (md_iter) begin
            e.alu = 0;
            e.r3  = 0;
`ifdef FAST_MUL_EN
            e.lat = (s.md_op <= 3'd2) ? 1 : W + 1;
`else
            e.lat = W + 1;
`endif
            model_md(s.md_op, s.rs_data, s.rt_data);
         end else begin
            e.r3  = s.reg_dst ? s.rd : s.rt;
            e.alu = (s.md_op == 3'd5) ? m_hi : (s.md_op == 3'd6) ? m_lo : model_alu(s.alu_ctrl, a, b);
            e.lat = 1;
         end
         if (!lat_chk) e.lat = -1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      id_valid = 1'b0;
   endtask

   task automatic resetDut();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ex_valid", 64'(ex_valid), 64'd0);
      checkOutput("rst_alu_out", 64'(alu_out), 64'd0);
      checkOutput("rst_store_data", 64'(store_data), 64'd0);
      checkOutput("rst_r3_addr", 64'(r3_addr), 64'd0);
      checkOutput("rst_md_busy", 64'(md_busy), 64'd0);
      sb.delete();
      m_hi = 0;
      m_lo = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ex_ready", 64'(ex_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: every MEM handshake retires the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && ex_valid && mem_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_output", 64'(ex_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("alu_out", 64'(alu_out), 64'(e.alu));
               checkOutput("r3_addr", 64'(r3_addr), 64'(e.r3));
               checkOutput("store_data", 64'(store_data), 64'(e.st));
               if (e.lat >= 0) checkOutput("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      stim_t s;
      int    w;
      int    r;
      rst_n = 0; id_valid = 0; mem_ready = 1;
      s = blank();
      alu_ctrl = 0; md_op = 0; alu_src_a = 1; alu_src_b = 0; is_shift = 0; reg_dst = 0;
      rt = 0; rd = 0; shamt = 0; rs_data = 0; rt_data = 0; imm = 0; immc = 0; pc_plus = 0;
      resetDut();

      s = blank(); s.rs_data = 5; s.imm = 32'hFFFF_FFFF; s.alu_src_b = 2; s.rt = 9;
      applyStimulus(s, 1, w);
      @(negedge clk);
      checkOutput("add_direct", 64'(alu_out), 64'h4);
      checkOutput("add_r3", 64'(r3_addr), 64'd9);
      @(posedge clk); #1;

      s = blank(); s.alu_ctrl = 8; s.is_shift = 1; s.shamt = 4; s.rt_data = 32'hF;
      s.reg_dst = 1; s.rd = 17;
      applyStimulus(s, 1, w);
      @(negedge clk);
      checkOutput("sll_direct", 64'(alu_out), 64'hF0);
      @(posedge clk); #1;

      s = blank(); s.alu_src_a = 0; s.pc_plus = 32'h100; s.alu_src_b = 1;
      applyStimulus(s, 1, w);
      @(negedge clk);
      checkOutput("pc_direct", 64'(alu_out), 64'h100);
      @(posedge clk); #1;

      s = blank(); s.md_op = 1; s.rs_data = -32'sd3; s.rt_data = 32'd7; s.rt = 4;
      applyStimulus(s, 1, w);
      s = blank(); s.md_op = 6; s.rt = 2;
      applyStimulus(s, 1, w);
`ifdef FAST_MUL_EN
      checkOutput("mult_ready_low", 64'(w), 64'd0);
`else
      checkOutput("mult_ready_low", 64'(w), 64'(W));
`endif
      s = blank(); s.md_op = 5; s.rt = 3;
      applyStimulus(s, 1, w);
      drain();

      s = blank(); s.md_op = 3; s.rs_data = -32'sd7; s.rt_data = 32'd2;
      applyStimulus(s, 1, w);
      s = blank(); s.md_op = 6;
      applyStimulus(s, 1, w);
      checkOutput("div_ready_low", 64'(w), 64'(W));
      s = blank(); s.md_op = 5;
      applyStimulus(s, 1, w);
      drain();

      s = blank(); s.md_op = 4; s.rs_data = 32'h1234_5678; s.rt_data = 0;
      applyStimulus(s, 1, w);
      s = blank(); s.md_op = 6;
      applyStimulus(s, 1, w);
      s = blank(); s.md_op = 5;
      applyStimulus(s, 1, w);
      drain();

      mem_ready = 0;
      s = blank(); s.alu_ctrl = 4; s.rs_data = 32'hA5A5_0F0F; s.rt_data = 32'h0FF0_1234;
      s.reg_dst = 1; s.rd = 21;
      applyStimulus(s, 0, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_ex_valid", 64'(ex_valid), 64'd1);
         checkOutput("stall_ex_ready", 64'(ex_ready), 64'd0);
         if (sb.size() != 0) begin
            checkOutput("stall_alu_out", 64'(alu_out), 64'(sb[0].alu));
            checkOutput("stall_r3_addr", 64'(r3_addr), 64'(sb[0].r3));
         end else begin
            checkOutput("stall_entry", 64'd0, 64'd1);
         end
      end
      @(posedge clk); #1;
      mem_ready = 1;
      drain();

      s = blank(); s.md_op = 3; s.rs_data = 32'd1000; s.rt_data = 32'd7;
      applyStimulus(s, 1, w);
      repeat (5) @(posedge clk);
      #1;
      resetDut();
      s = blank(); s.md_op = 5;
      applyStimulus(s, 1, w);
      s = blank(); s.md_op = 6;
      applyStimulus(s, 1, w);
      drain();

      rand_on = 1;
      fork
         begin
            while (rand_on) begin
               @(posedge clk); #1;
               mem_ready = ($urandom_range(0, 3) != 0);
            end
            mem_ready = 1;
         end
      join_none
      for (int n = 0; n < 150; n++) begin
         s.alu_ctrl  = 4'($urandom_range(0, 11));
         r = $urandom_range(0, 19);
         s.md_op     = (r < 12 || r == 19) ? 3'd0 : (r == 18) ? 3'd7 : 3'(r - 11);
         s.alu_src_a = ($urandom_range(0, 3) != 0);
         s.alu_src_b = 2'($urandom_range(0, 3));
         s.is_shift  = $urandom_range(0, 1);
         s.reg_dst   = $urandom_range(0, 1);
         s.rt = AW'($urandom); s.rd = AW'($urandom); s.shamt = SW'($urandom);
         s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
         s.immc = $urandom; s.pc_plus = $urandom;
         r = $urandom_range(0, 7);
         if (r == 0) s.rt_data = 0;
         else if (r == 1) begin s.rs_data = 32'h8000_0000; s.rt_data = 32'hFFFF_FFFF; end
         else if (r == 2) s.rt_data = $urandom_range(1, 9);
         applyStimulus(s, 0, w);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rand_on = 0;
      repeat (2) @(posedge clk);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
